// File: rtl/sync_fifo_pkg.sv
// ============================================================================
// Module   : sync_fifo_pkg
// Purpose  : Shared width helpers and error-status type for sync_fifo_param.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

package sync_fifo_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so the level can represent DEPTH itself.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_status_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo_param_if.sv
// ============================================================================
// Module   : sync_fifo_param_if
// Purpose  : Producer/consumer handshake bundle for sync_fifo_param.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int c_lvl_w = lvl_w(DEPTH);

  logic               wr_en_i;
  logic [WIDTH-1:0]   wr_data_i;
  logic               rd_en_i;
  logic               err_clr_i;
  logic [WIDTH-1:0]   rd_data_o;
  logic               rd_valid_o;
  logic               full_o;
  logic               empty_o;
  logic               almost_full_o;
  logic               almost_empty_o;
  logic [c_lvl_w-1:0] level_o;
  logic               overflow_o;
  logic               underflow_o;

  modport slave (
    input  wr_en_i, wr_data_i, rd_en_i, err_clr_i,
    output rd_data_o, rd_valid_o, full_o, empty_o, almost_full_o,
           almost_empty_o, level_o, overflow_o, underflow_o
  );

  modport master (
    output wr_en_i, wr_data_i, rd_en_i, err_clr_i,
    input  rd_data_o, rd_valid_o, full_o, empty_o, almost_full_o,
           almost_empty_o, level_o, overflow_o, underflow_o
  );

endinterface

`default_nettype wire

// File: rtl/sync_fifo_mem.sv
// ============================================================================
// Module   : sync_fifo_mem
// Purpose  : DEPTH x WIDTH storage, one write port and one read port.
//            Registered read; asynchronous read when SYNC_FIFO_FWFT_EN.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = ptr_w(DEPTH)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      r_mem[wr_addr_i] <= wr_data_i;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic w_unused;
  assign w_unused  = reset_i ^ rd_en_i;
  assign rd_data_o = r_mem[rd_addr_i];
`else
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_rd_data <= '0;
    end else if (rd_en_i) begin
      r_rd_data <= r_mem[rd_addr_i];
    end
  end

  assign rd_data_o = r_rd_data;
`endif

endmodule

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// ============================================================================
// Module   : sync_fifo_param
// Purpose  : Parametrised single-clock FIFO with level, thresholds and
//            sticky errors. Define SYNC_FIFO_FWFT_EN for first-word-fall-through.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  sync_fifo_param_if.slave bus
);

  localparam int                 c_ptr_w   = ptr_w(DEPTH);
  localparam int                 c_lvl_w   = lvl_w(DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [c_lvl_w-1:0] c_lvl_one = c_lvl_w'(1);
  localparam logic [c_lvl_w-1:0] c_depth   = c_lvl_w'(DEPTH);
  localparam logic [c_lvl_w-1:0] c_af      = c_lvl_w'(AF_THRESH);
  localparam logic [c_lvl_w-1:0] c_ae      = c_lvl_w'(AE_THRESH);

  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_lvl_w-1:0] r_level;
  err_status_t        r_err;

  logic               w_full;
  logic               w_empty;
  logic               w_wr_acc;
  logic               w_rd_acc;
  logic [WIDTH-1:0]   w_rd_data;

  // Flags decode only the registered level, so inputs never reach them.
  assign w_full   = (r_level == c_depth);
  assign w_empty  = (r_level == '0);
  assign w_wr_acc = bus.wr_en_i & ~w_full;
  assign w_rd_acc = bus.rd_en_i & ~w_empty;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_err    <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_wr_acc && !w_rd_acc) begin
        r_level <= r_level + c_lvl_one;
      end else if (w_rd_acc && !w_wr_acc) begin
        r_level <= r_level - c_lvl_one;
      end
      // A fresh error outranks a simultaneous clear.
      r_err.overflow  <= (bus.wr_en_i & w_full)
                       | (r_err.overflow & ~bus.err_clr_i);
      r_err.underflow <= (bus.rd_en_i & w_empty)
                       | (r_err.underflow & ~bus.err_clr_i);
    end
  end

  sync_fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (c_ptr_w)
  ) u_mem (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .wr_en_i   (w_wr_acc),
    .wr_addr_i (r_wr_ptr),
    .wr_data_i (bus.wr_data_i),
    .rd_en_i   (w_rd_acc),
    .rd_addr_i (r_rd_ptr),
    .rd_data_o (w_rd_data)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.rd_valid_o = ~w_empty;
`else
  logic r_rd_valid;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
    end
  end

  assign bus.rd_valid_o = r_rd_valid;
`endif

  assign bus.rd_data_o      = w_rd_data;
  assign bus.full_o         = w_full;
  assign bus.empty_o        = w_empty;
  assign bus.almost_full_o  = (r_level >= c_af);
  assign bus.almost_empty_o = (r_level <= c_ae);
  assign bus.level_o        = r_level;
  assign bus.overflow_o     = r_err.overflow;
  assign bus.underflow_o    = r_err.underflow;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// ============================================================================
// Module   : tb_sync_fifo_param
// Purpose  : Directed self-checking bench for sync_fifo_param (8x8, AF=6, AE=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_param;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  sync_fifo_param_if #(.WIDTH(8), .DEPTH(8)) bus ();

  sync_fifo_param #(
    .WIDTH     (8),
    .DEPTH     (8),
    .AF_THRESH (6),
    .AE_THRESH (2)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_en_i   = 1'b1;
    bus.wr_data_i = d;
    tick();
    bus.wr_en_i   = 1'b0;
  endtask

  initial begin
    logic [7:0] tail [7];
    tail = '{8'h35, 8'h36, 8'h37, 8'h40, 8'h41, 8'h42, 8'h43};

    bus.wr_en_i   = 1'b0;
    bus.wr_data_i = '0;
    bus.rd_en_i   = 1'b0;
    bus.err_clr_i = 1'b0;
    tick();
    tick();
    check("rst_empty", bus.empty_o, 1);
    check("rst_full", bus.full_o, 0);
    check("rst_level", bus.level_o, 0);
    check("rst_ae", bus.almost_empty_o, 1);
    check("rst_af", bus.almost_full_o, 0);
    check("rst_valid", bus.rd_valid_o, 0);
    check("rst_ovf", bus.overflow_o, 0);
    check("rst_unf", bus.underflow_o, 0);
    reset_i = 1'b1;
    tick();

`ifdef SYNC_FIFO_FWFT_EN
    push(8'h5A);
    check("fwft_valid", bus.rd_valid_o, 1);
    check("fwft_data", bus.rd_data_o, 8'h5A);
    check("fwft_level", bus.level_o, 1);
    bus.rd_en_i = 1'b1;
    tick();
    bus.rd_en_i = 1'b0;
    check("fwft_empty", bus.empty_o, 1);
    check("fwft_novalid", bus.rd_valid_o, 0);
    push(8'h61);
    push(8'h62);
    check("fwft_head0", bus.rd_data_o, 8'h61);
    bus.rd_en_i = 1'b1;
    tick();
    bus.rd_en_i = 1'b0;
    check("fwft_head1", bus.rd_data_o, 8'h62);
    check("fwft_level1", bus.level_o, 1);
`else
    // Fill with 0x10..0x17.
    for (int i = 0; i < 8; i++) begin
      push(8'h10 + 8'(i));
      check($sformatf("fill_level%0d", i), bus.level_o, 32'(i + 1));
      check($sformatf("fill_af%0d", i), bus.almost_full_o, ((i + 1) >= 6));
      check($sformatf("fill_ae%0d", i), bus.almost_empty_o, ((i + 1) <= 2));
      check($sformatf("fill_full%0d", i), bus.full_o, ((i + 1) == 8));
    end

    push(8'hAA);
    check("ovf_set", bus.overflow_o, 1);
    check("ovf_level", bus.level_o, 8);
    bus.err_clr_i = 1'b1;
    tick();
    bus.err_clr_i = 1'b0;
    check("ovf_clr", bus.overflow_o, 0);

    for (int i = 0; i < 8; i++) begin
      bus.rd_en_i = 1'b1;
      tick();
      check($sformatf("drain_data%0d", i), bus.rd_data_o, 8'h10 + 8'(i));
      check($sformatf("drain_valid%0d", i), bus.rd_valid_o, 1);
      check($sformatf("drain_level%0d", i), bus.level_o, 32'(7 - i));
    end
    bus.rd_en_i = 1'b0;
    tick();
    check("drain_novalid", bus.rd_valid_o, 0);
    check("drain_empty", bus.empty_o, 1);

    bus.rd_en_i = 1'b1;
    tick();
    bus.rd_en_i = 1'b0;
    check("unf_set", bus.underflow_o, 1);
    check("unf_valid", bus.rd_valid_o, 0);
    check("unf_data", bus.rd_data_o, 8'h17);
    check("unf_level", bus.level_o, 0);
    bus.err_clr_i = 1'b1;
    tick();
    bus.err_clr_i = 1'b0;
    check("unf_clr", bus.underflow_o, 0);

    // Hold level 4 while both pointers wrap twice.
    for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
    bus.wr_en_i = 1'b1;
    bus.rd_en_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.wr_data_i = 8'h24 + 8'(k);
      tick();
      check($sformatf("sim_data%0d", k), bus.rd_data_o, 8'h20 + 8'(k));
      check($sformatf("sim_level%0d", k), bus.level_o, 4);
      check($sformatf("sim_valid%0d", k), bus.rd_valid_o, 1);
    end
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;

    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
    check("sim_full", bus.full_o, 1);
    bus.wr_en_i   = 1'b1;
    bus.rd_en_i   = 1'b1;
    bus.wr_data_i = 8'hBB;
    tick();
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    check("fullboth_level", bus.level_o, 7);
    check("fullboth_ovf", bus.overflow_o, 1);
    check("fullboth_data", bus.rd_data_o, 8'h34);

    for (int i = 0; i < 7; i++) begin
      bus.rd_en_i = 1'b1;
      tick();
      check($sformatf("tail_data%0d", i), bus.rd_data_o, tail[i]);
    end
    bus.rd_en_i   = 1'b0;
    bus.err_clr_i = 1'b1;
    tick();
    bus.err_clr_i = 1'b0;
    check("clr_both_ovf", bus.overflow_o, 0);

    bus.wr_en_i   = 1'b1;
    bus.rd_en_i   = 1'b1;
    bus.wr_data_i = 8'h55;
    tick();
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    check("emptyboth_level", bus.level_o, 1);
    check("emptyboth_unf", bus.underflow_o, 1);
    check("emptyboth_valid", bus.rd_valid_o, 0);

    bus.rd_en_i = 1'b1;
    tick();
    check("emptyboth_data", bus.rd_data_o, 8'h55);
    bus.err_clr_i = 1'b1;
    tick();
    bus.rd_en_i   = 1'b0;
    check("setwins_unf", bus.underflow_o, 1);
    tick();
    bus.err_clr_i = 1'b0;
    check("clr_unf", bus.underflow_o, 0);
`endif

    // Asynchronous reset between clock edges.
    push(8'h77);
    #2;
    reset_i = 1'b0;
    #1;
    check("async_level", bus.level_o, 0);
    check("async_empty", bus.empty_o, 1);
    check("async_valid", bus.rd_valid_o, 0);
    tick();
    reset_i = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised synchronous FIFO; next generation of the team's 8-entry single-bit FIFO.
- Adds:
  - configurable data width and depth
  - occupancy level output
  - programmable almost-full and almost-empty thresholds
  - sticky overflow and underflow error flags
  - read-valid strobe
- Sits between producer and consumer logic in a single clock domain. Used as the generic buffering primitive.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 8, number of entries. Must be a power of two, >=2.
- AF_THRESH, DEPTH-2, almost_full_o asserts when level >= AF_THRESH. Range 1..DEPTH.
- AE_THRESH, 2, almost_empty_o asserts when level <= AE_THRESH. Range 0..DEPTH-1.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- wr_en_i  input  1  write request.
- wr_data_i  input  WIDTH  write data.
- rd_en_i  input  1  read request.
- rd_data_o  output  WIDTH  read data.
- rd_valid_o  output  1  rd_data_o carries a newly read word.
- full_o  output  1  level == DEPTH.
- empty_o  output  1  level == 0.
- almost_full_o  output  1  level >= AF_THRESH.
- almost_empty_o  output  1  level <= AE_THRESH.
- level_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow_o  output  1  sticky: write attempted while full.
- underflow_o  output  1  sticky: read attempted while empty.
- err_clr_i  input  1  synchronous clear of overflow_o and underflow_o.

Behaviour:
- Reset (reset_i low, asynchronous): outputs and state take these values and hold while reset_i is low.
  - wr_ptr=0, rd_ptr=0, level=0
  - rd_data_o=0, rd_valid_o=0
  - overflow_o=0, underflow_o=0
  - Resulting flags: empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=(AF_THRESH==0 ? 1 : 0).
  - Reset mid-operation discards all contents. Memory array is not cleared.
- Write accept: wr_acc = wr_en_i & ~full_o. On wr_acc:
  - mem[wr_ptr] <= wr_data_i
  - wr_ptr increments modulo DEPTH.
- Read accept: rd_acc = rd_en_i & ~empty_o. On rd_acc:
  - rd_data_o <= mem[rd_ptr]
  - rd_ptr increments modulo DEPTH.
- Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
- Read latency: 1 cycle.
  - rd_valid_o = registered rd_acc, i.e. high exactly one cycle after each accepted read.
  - rd_data_o holds its last value when no read is accepted.
- Level update (registered):
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged on both or neither.
  - No width overflow possible: level width holds DEPTH.
- Simultaneous read and write:
  - When full: only the read is accepted; the write is rejected and overflow_o sets. Level goes DEPTH -> DEPTH-1.
  - When empty: only the write is accepted; the read is rejected and underflow_o sets. Level goes 0 -> 1.
  - Otherwise both are accepted and the level is unchanged.
- Flags: full_o, empty_o, almost_full_o, almost_empty_o and level_o are decoded from the registered level only. They update the cycle after the accepting edge, with no combinational path from inputs.
- Errors:
  - overflow_o sets on wr_en_i & full_o.
  - underflow_o sets on rd_en_i & empty_o.
  - Both are sticky until err_clr_i. If err_clr_i and a new error occur in the same cycle, the set wins.
  - A rejected access never changes the pointers, level or memory.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - rd_data_o = mem[rd_ptr] combinationally whenever ~empty_o.
  - rd_valid_o = ~empty_o.
  - rd_en_i acts as acknowledge: it pops the head word with 0-cycle latency.
  - The value on rd_data_o when empty is don't-care.
- Not defined: standard 1-cycle registered read as described above.
- Level, flags and error behaviour are identical in both modes.

Decomposition:
- Package sync_fifo_pkg contains:
  - localparam function for pointer width (clog2)
  - level-width helper
  - typedef for the error-status struct {overflow, underflow}.
- One natural sub-module: sync_fifo_mem, a DEPTH x WIDTH array with one write port and one read port. It has a registered read port, or an asynchronous read port under SYNC_FIFO_FWFT_EN.
- Control (pointers, level, flags, errors) stays in sync_fifo_param.

Test Plan:
All scenarios use WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=2 unless noted.
- Reset: hold reset_i=0 for 2 cycles -> empty_o=1, full_o=0, level_o=0, almost_empty_o=1, rd_valid_o=0, overflow_o=underflow_o=0.
- Fill then drain:
  - Write 0x10..0x17 on 8 consecutive cycles -> level_o steps 1..8; almost_full_o high at level 6; full_o high at level 8.
  - Then read 8 -> rd_data_o=0x10..0x17 in order, each one cycle after its rd_en_i, with rd_valid_o high; empty_o=1 at end.
- Overflow and clear:
  - When full, write 0xAA -> overflow_o=1, level stays 8, and a later read of the 8th word returns 0x17, not 0xAA.
  - Pulse err_clr_i -> overflow_o=0.
- Underflow: read while empty -> underflow_o=1, rd_valid_o stays 0, rd_data_o unchanged, level stays 0.
- Simultaneous access:
  - At level 4, wr_en_i=rd_en_i=1 for 20 cycles with incrementing data -> level_o constant at 4 and pointers wrap at least twice; data order preserved.
  - At full, both asserted -> level becomes 7 and overflow_o=1.
- FWFT (build with SYNC_FIFO_FWFT_EN): write 0x5A into an empty FIFO -> next cycle rd_valid_o=1 and rd_data_o=0x5A. Assert rd_en_i -> empty_o=1 the following cycle.
